// File: rtl/gemv_ctrl_if.sv
// Handshake/strobe bundle between the GEMV sequencer, the layer scheduler and the datapath.
// master = sequencer side (gemv_ctrl), slave = scheduler/datapath side.
interface gemv_ctrl_if #(
    parameter int ROWS      = 128,
    parameter int COLUMNS   = 128,
    parameter int TILE_SIZE = 8
);
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(COLUMNS / TILE_SIZE);

    logic          start;
    logic [RW:0]   num_rows;
    logic [TW:0]   num_tiles;
    logic          busy;
    logic          done;
    logic          err;
    logic          tile_vld;
    logic          tile_rdy;
    logic [RW-1:0] row_idx;
    logic [TW-1:0] tile_idx;
    logic          acc_en;
    logic          acc_first;
    logic          bias_en;
    logic          wb_en;

    modport master (
        input  start, num_rows, num_tiles, tile_rdy,
        output busy, done, err, tile_vld, row_idx, tile_idx,
               acc_en, acc_first, bias_en, wb_en
    );

    modport slave (
        output start, num_rows, num_tiles, tile_rdy,
        input  busy, done, err, tile_vld, row_idx, tile_idx,
               acc_en, acc_first, bias_en, wb_en
    );
endinterface

// File: rtl/gemv_ctrl.sv
// Row/tile sequencer for the tiled GEMV datapath: issues tiles, then bias and writeback per row.
// Define GEMV_CTRL_PERF_EN to add the stall_cnt performance counter output.
module gemv_ctrl #(
    parameter int ROWS       = 128,
    parameter int COLUMNS    = 128,
    parameter int TILE_SIZE  = 8,
    parameter int PE_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef GEMV_CTRL_PERF_EN
    output logic [31:0]   stall_cnt,
`endif
    gemv_ctrl_if.master   bus
);
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(COLUMNS / TILE_SIZE);
    localparam int NT = COLUMNS / TILE_SIZE;
    localparam int DW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] BIAS  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]            state;
    logic [RW:0]           lim_rows;
    logic [TW:0]           lim_tiles;
    logic [RW-1:0]         row_idx;
    logic [TW-1:0]         tile_idx;
    logic [DW-1:0]         drain_cnt;
    logic                  err_q;
    logic [PE_LATENCY-1:0] acc_pipe;
    logic [PE_LATENCY-1:0] first_pipe;
    logic                  hs;
    logic                  job_bad;
    logic                  last_tile;
    logic                  last_row;

    assign hs        = (state == ISSUE) && bus.tile_rdy;
    assign job_bad   = (bus.num_rows == '0) || (bus.num_rows > (RW+1)'(ROWS)) ||
                       (bus.num_tiles == '0) || (bus.num_tiles > (TW+1)'(NT));
    assign last_tile = ({1'b0, tile_idx} == lim_tiles - (TW+1)'(1));
    assign last_row  = ({1'b0, row_idx} >= lim_rows - (RW+1)'(1));

    // Main sequencer; indices only move on handshakes or at row boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lim_rows  <= '0;
            lim_tiles <= '0;
            row_idx   <= '0;
            tile_idx  <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lim_rows  <= bus.num_rows;
                        lim_tiles <= bus.num_tiles;
                        row_idx   <= '0;
                        tile_idx  <= '0;
                        if (job_bad) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        if (last_tile) begin
                            tile_idx  <= '0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            tile_idx <= tile_idx + TW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(PE_LATENCY - 1)) begin
                        state <= BIAS;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                BIAS: state <= WRITE;
                WRITE: begin
                    if (last_row) begin
                        state <= DONE;
                    end else begin
                        row_idx <= row_idx + RW'(1);
                        state   <= ISSUE;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // PE sum valid pipeline: acc_en trails each handshake by PE_LATENCY cycles.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            acc_pipe   <= '0;
            first_pipe <= '0;
        end else begin
            acc_pipe   <= (acc_pipe << 1)   | PE_LATENCY'(hs);
            first_pipe <= (first_pipe << 1) | PE_LATENCY'(hs && tile_idx == '0);
        end
    end

`ifdef GEMV_CTRL_PERF_EN
    // Stall counter survives done so software can read it after the job.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && bus.start) begin
            stall_cnt <= '0;
        end else if (state == ISSUE && !bus.tile_rdy && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.err       = err_q;
    assign bus.tile_vld  = (state == ISSUE);
    assign bus.row_idx   = row_idx;
    assign bus.tile_idx  = tile_idx;
    assign bus.acc_en    = acc_pipe[PE_LATENCY-1];
    assign bus.acc_first = first_pipe[PE_LATENCY-1];
    assign bus.bias_en   = (state == BIAS);
    assign bus.wb_en     = (state == WRITE);
endmodule
